fir_mac_filter: RTL and testbench
=================================

Name: fir_mac_filter

Overview:
- Parametrised, time-multiplexed FIR filter with run-time loadable coefficients. Successor to the fixed 31-tap pass-through FIR stub.
- Sits between the sampled-mic path and volume_control, driven by the 48 kHz sample_trigger strobe.
- Uses one multiplier per clock over a circular sample buffer.
- Produces a full-precision result and a scaled, saturated DATA_W result.

Parameters:
- TAPS, 31: number of taps; legal range 2..64.
- DATA_W, 8: signed sample width (input and scaled output).
- COEFF_W, 10: signed coefficient width.
- COEFF_FRAC, 10: right arithmetic shift applied to form the scaled output.
- ACC_W, DATA_W+COEFF_W+$clog2(TAPS): signed accumulator and y_out width.

Ports:
- clk_in  in  1  system clock (100 MHz).
- rst_in  in  1  asynchronous, active-low reset.
- ready_in  in  1  one-cycle strobe: new sample on x_in.
- x_in  in  DATA_W  signed input sample.
- coeff_we_in  in  1  coefficient write strobe.
- coeff_addr_in  in  $clog2(TAPS)  coefficient index k.
- coeff_data_in  in  COEFF_W  signed coefficient value.
- busy_out  out  1  MAC in progress.
- y_valid_out  out  1  one-cycle pulse: new result on y_out and y_scaled_out.
- y_out  out  ACC_W  signed full-precision sum of c[k]*x[n-k].
- y_scaled_out  out  DATA_W  saturate(y_out >>> COEFF_FRAC).
- sat_out  out  1  high when y_scaled_out was clipped; held with the result.
- overrun_out  out  1  one-cycle pulse: ready_in rejected.
- coeff_err_out  out  1  one-cycle pulse: coefficient write rejected.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All outputs 0.
  - Sample buffer, coefficient array, accumulator, write pointer and tap counter cleared.
  - FSM to IDLE.
  - Takes effect immediately, including mid-MAC; the partial result is discarded and no y_valid_out is issued.
- FSM states: IDLE, MAC, DONE.
- IDLE: ready_in=1 at edge E0 has three effects:
  - x_in is written to buffer[wp].
  - wp advances, wrapping TAPS-1 -> 0.
  - acc<=0, k<=0, state->MAC, busy_out=1 after E0.
- MAC, edges E1..E_TAPS: acc += c[k]*buffer[(newest - k) mod TAPS], k++. Exactly TAPS products, one per edge.
- Transition MAC -> DONE after product k=TAPS-1.
- DONE, edge E_TAPS+1:
  - y_out<=acc, y_scaled_out and sat_out updated, y_valid_out=1 for one cycle.
  - busy_out=0, state->IDLE.
- Latency: result visible TAPS+1 edges after the sampling edge.
- Minimum ready_in spacing: TAPS+2 cycles. Sample period 2083 cycles, so ample margin.
- ready_in while state != IDLE (including the DONE edge):
  - Sample dropped; buffer and wp unchanged.
  - overrun_out pulses 1 cycle.
  - In-flight result unaffected.
- Arithmetic:
  - Products are full DATA_W+COEFF_W signed, sign-extended to ACC_W.
  - No overflow is possible by construction of ACC_W.
  - Shift is arithmetic, truncating toward -inf.
  - Scaled saturation limits: max 2^(DATA_W-1)-1, min -2^(DATA_W-1); sat_out=1 when either limit is applied.
- Coefficient write (coeff_we_in=1):
  - In IDLE with coeff_addr_in < TAPS: c[addr]<=coeff_data_in at that edge.
  - While busy_out=1, or with addr >= TAPS: write ignored, coeff_err_out pulses.
  - Simultaneous legal write and ready_in in IDLE: the write lands first, so the new coefficient is used for that sample.
- y_out, y_scaled_out and sat_out hold their values between y_valid_out pulses.

Test Plan:
- Reset during MAC (assert rst_in=0 at E15 of a run) -> all outputs 0 immediately. After release, impulse 100 with all coefficients 0 -> y_out=0, y_valid_out at E32.
- Impulse response: c[k]=k+1 (k=0..30), feed x=100 then 30 zeros -> y_out = 100, 200, …, 3100 on successive results, then 0. The first y_valid_out is exactly 32 edges after the first ready_in.
- DC gain: all c=32, feed x=127 for 40 samples -> from the 31st result onward y_out=125984, y_scaled_out=123, sat_out=0.
- Saturation: all c=511:
  - x=127 constant -> y_out=2011807, y_scaled_out=127, sat_out=1.
  - x=-128 constant -> y_out=-2027648, y_scaled_out=-128, sat_out=1.
- Overrun: ready_in at E0 and again at E10 (x=55) -> overrun_out pulses at E10. The result equals the E0-only case, and the next accepted sample occupies the slot 55 would have.
- Coefficient errors (each -> coeff_err_out pulse, coefficient array unchanged):
  - Write addr=31.
  - Write addr=3 during busy.
- Coefficient/sample collision: a legal write c[0]=7 in the same edge as ready_in x=10 (all other c=0) -> y_out=70.

Source files
------------

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR: one signed multiply per clock over a circular sample buffer, run-time loadable coefficients.
// Latency: result (y_out, y_scaled_out, sat_out) and y_valid_out appear TAPS+1 edges after the accepting ready_in edge.
// Backpressure: none; ready_in outside IDLE is dropped with an overrun_out pulse, illegal coefficient writes pulse coeff_err_out.
module fir_mac_filter #(
  parameter int TAPS       = 31,
  parameter int DATA_W     = 8,
  parameter int COEFF_W    = 10,
  parameter int COEFF_FRAC = 10,
  parameter int ACC_W      = DATA_W + COEFF_W + $clog2(TAPS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      ready_in,
  input  logic signed [DATA_W-1:0]  x_in,
  input  logic                      coeff_we_in,
  input  logic [$clog2(TAPS)-1:0]   coeff_addr_in,
  input  logic signed [COEFF_W-1:0] coeff_data_in,
  output logic                      busy_out,
  output logic                      y_valid_out,
  output logic signed [ACC_W-1:0]   y_out,
  output logic signed [DATA_W-1:0]  y_scaled_out,
  output logic                      sat_out,
  output logic                      overrun_out,
  output logic                      coeff_err_out
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEFF_W;
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  buf_q   [TAPS];
  logic signed [COEFF_W-1:0] coeff_q [TAPS];
  logic signed [ACC_W-1:0]   acc_q;
  logic [AW-1:0]             wp_q;
  logic [AW-1:0]             newest_q;
  logic [AW-1:0]             k_q;
  logic signed [ACC_W-1:0]   y_q;
  logic signed [DATA_W-1:0]  ys_q;
  logic                      sat_q;
  logic                      yv_q;
  logic                      ovr_q;
  logic                      cerr_q;

  logic                      accept;
  logic                      mac_en;
  logic                      done;
  logic                      coeff_ok;
  logic [AW:0]               idx_w;
  logic [AW-1:0]             tap_idx;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [DATA_W-1:0]  scaled_d;
  logic                      sat_d;

  // Coefficient writes are only legal while idle and in range; an idle write lands before a same-edge sample starts its MAC.
  assign coeff_ok = coeff_we_in && (state_q == IDLE) && ({1'b0, coeff_addr_in} < (AW+1)'(TAPS));

  // Walk backwards from the newest sample: tap k reads buffer[(newest - k) mod TAPS].
  always_comb begin
    idx_w = '0;
    if (newest_q >= k_q) idx_w = {1'b0, newest_q} - {1'b0, k_q};
    else                 idx_w = {1'b0, newest_q} + (AW+1)'(TAPS) - {1'b0, k_q};
  end
  assign tap_idx = idx_w[AW-1:0];
  assign prod    = buf_q[tap_idx] * coeff_q[k_q];

  // Arithmetic shift floors toward -inf, then clamp to the signed DATA_W range.
  assign shifted = acc_q >>> COEFF_FRAC;
  always_comb begin
    scaled_d = shifted[DATA_W-1:0];
    sat_d    = 1'b0;
    if (shifted > SMAX) begin
      scaled_d = SMAX[DATA_W-1:0];
      sat_d    = 1'b1;
    end else if (shifted < SMIN) begin
      scaled_d = SMIN[DATA_W-1:0];
      sat_d    = 1'b1;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mac_en  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_in) begin
          accept  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == AW'(TAPS - 1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Sample buffer, coefficients, accumulator and result registers; reset discards any partial sum.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < TAPS; i++) begin
        buf_q[i]   <= '0;
        coeff_q[i] <= '0;
      end
      acc_q    <= '0;
      wp_q     <= '0;
      newest_q <= '0;
      k_q      <= '0;
      y_q      <= '0;
      ys_q     <= '0;
      sat_q    <= 1'b0;
      yv_q     <= 1'b0;
      ovr_q    <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      yv_q   <= done;
      ovr_q  <= ready_in && (state_q != IDLE);
      cerr_q <= coeff_we_in && !coeff_ok;
      if (coeff_ok) coeff_q[coeff_addr_in] <= coeff_data_in;
      if (accept) begin
        buf_q[wp_q] <= x_in;
        newest_q    <= wp_q;
        wp_q        <= (wp_q == AW'(TAPS - 1)) ? '0 : wp_q + 1'b1;
        acc_q       <= '0;
        k_q         <= '0;
      end
      if (mac_en) begin
        acc_q <= acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
        k_q   <= k_q + 1'b1;
      end
      if (done) begin
        y_q   <= acc_q;
        ys_q  <= scaled_d;
        sat_q <= sat_d;
      end
    end
  end

  assign busy_out      = (state_q != IDLE);
  assign y_valid_out   = yv_q;
  assign y_out         = y_q;
  assign y_scaled_out  = ys_q;
  assign sat_out       = sat_q;
  assign overrun_out   = ovr_q;
  assign coeff_err_out = cerr_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Self-checking bench for fir_mac_filter with a behavioural FIR model feeding a result scoreboard.
// Latency: checks every result arrives exactly TAPS+1 edges after its accepting edge.
// Backpressure: exercises dropped samples (overrun) and rejected coefficient writes.
module tb_fir_mac_filter;
  localparam int TAPS = 31;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              ready_in;
  logic signed [7:0] x_in;
  logic              coeff_we_in;
  logic [4:0]        coeff_addr_in;
  logic signed [9:0] coeff_data_in;
  logic              busy_out;
  logic              y_valid_out;
  logic signed [22:0] y_out;
  logic signed [7:0] y_scaled_out;
  logic              sat_out;
  logic              overrun_out;
  logic              coeff_err_out;

  always #5 clk_in = ~clk_in;

  fir_mac_filter dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .ready_in      (ready_in),
    .x_in          (x_in),
    .coeff_we_in   (coeff_we_in),
    .coeff_addr_in (coeff_addr_in),
    .coeff_data_in (coeff_data_in),
    .busy_out      (busy_out),
    .y_valid_out   (y_valid_out),
    .y_out         (y_out),
    .y_scaled_out  (y_scaled_out),
    .sat_out       (sat_out),
    .overrun_out   (overrun_out),
    .coeff_err_out (coeff_err_out)
  );

  typedef struct {
    longint y;
    longint ys;
    longint sat;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  longint c_m[TAPS];
  longint h_m[TAPS];
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      c_m[k] = 0;
      h_m[k] = 0;
    end
    sb_q.delete();
  endtask

  // Model: h_m[k] holds x[n-k]; expectation pushed at the accepting edge.
  task automatic model_sample(input longint x);
    exp_t   e;
    longint acc;
    longint sh;
    for (int k = TAPS - 1; k > 0; k--) h_m[k] = h_m[k-1];
    h_m[0] = x;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += c_m[k] * h_m[k];
    sh    = acc >>> 10;
    e.y   = acc;
    e.sat = 0;
    if (sh > 127) begin
      e.ys = 127; e.sat = 1;
    end else if (sh < -128) begin
      e.ys = -128; e.sat = 1;
    end else begin
      e.ys = sh;
    end
    sb_q.push_back(e);
  endtask

  // Scoreboard consumer: compare every result pulse against the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_in && y_valid_out) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_y_out", longint'(y_out), mon_e.y);
        chk("sb_y_scaled", longint'(y_scaled_out), mon_e.ys);
        chk("sb_sat", longint'(sat_out), mon_e.sat);
      end
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, longint'(busy_out), 0);
    chk({tag, "_valid"}, longint'(y_valid_out), 0);
    chk({tag, "_y"}, longint'(y_out), 0);
    chk({tag, "_ys"}, longint'(y_scaled_out), 0);
    chk({tag, "_sat"}, longint'(sat_out), 0);
    chk({tag, "_ovr"}, longint'(overrun_out), 0);
    chk({tag, "_cerr"}, longint'(coeff_err_out), 0);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #3;
    model_clear();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_coeff(input int addr, input int data, input bit expect_err);
    coeff_we_in   = 1'b1;
    coeff_addr_in = addr[4:0];
    coeff_data_in = data[9:0];
    @(posedge clk_in);
    #1;
    coeff_we_in = 1'b0;
    chk("coeff_err", longint'(coeff_err_out), longint'(expect_err));
    if (!expect_err) c_m[addr] = data;
  endtask

  task automatic set_all_coeffs(input int v);
    for (int k = 0; k < TAPS; k++) write_coeff(k, v, 1'b0);
  endtask

  task automatic drive_sample(input int x);
    ready_in = 1'b1;
    x_in     = x[7:0];
    @(posedge clk_in);
    #1;
    ready_in = 1'b0;
    model_sample(x);
    chk("busy_set", longint'(busy_out), 1);
  endtask

  task automatic wait_result(input int exp_edges);
    int n;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk_in);
      #1;
      if (y_valid_out) begin
        n = i;
        break;
      end
    end
    chk("latency", n, exp_edges);
    chk("busy_clr", longint'(busy_out), 0);
  endtask

  initial begin
    rst_in        = 1'b0;
    ready_in      = 1'b0;
    x_in          = '0;
    coeff_we_in   = 1'b0;
    coeff_addr_in = '0;
    coeff_data_in = '0;
    model_clear();
    #23;
    chk_outputs_zero("rst");
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Reset in the middle of a MAC run discards the partial result.
    for (int k = 0; k < TAPS; k++) write_coeff(k, k + 1, 1'b0);
    drive_sample(100);
    repeat (15) @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    chk_outputs_zero("rst_mid");
    model_clear();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    drive_sample(100);
    wait_result(32);
    chk("rst_imp_y", longint'(y_out), 0);

    // Impulse response walks out the coefficient ramp.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coeff(k, k + 1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      drive_sample((i == 0) ? 100 : 0);
      wait_result(32);
      chk("imp_y", longint'(y_out), (i < 31) ? 100 * (i + 1) : 0);
    end

    // Overrun: second strobe at E10 is dropped; following sample takes its slot.
    drive_sample(20);
    repeat (9) @(posedge clk_in);
    #1;
    ready_in = 1'b1;
    x_in     = 8'sd55;
    @(posedge clk_in);
    #1;
    ready_in = 1'b0;
    chk("ovr_pulse", longint'(overrun_out), 1);
    chk("ovr_busy", longint'(busy_out), 1);
    @(posedge clk_in);
    #1;
    chk("ovr_clr", longint'(overrun_out), 0);
    wait_result(21);
    drive_sample(-7);
    wait_result(32);

    // Rejected coefficient writes leave the array untouched.
    write_coeff(31, 99, 1'b1);
    drive_sample(50);
    write_coeff(3, 0, 1'b1);
    wait_result(31);

    // Same-edge legal write and sample: new coefficient applies to that sample.
    set_all_coeffs(0);
    ready_in      = 1'b1;
    x_in          = 8'sd10;
    coeff_we_in   = 1'b1;
    coeff_addr_in = 5'd0;
    coeff_data_in = 10'sd7;
    @(posedge clk_in);
    #1;
    ready_in    = 1'b0;
    coeff_we_in = 1'b0;
    c_m[0]      = 7;
    model_sample(10);
    chk("coll_err", longint'(coeff_err_out), 0);
    wait_result(32);
    chk("coll_y", longint'(y_out), 70);

    // DC gain.
    set_all_coeffs(32);
    for (int i = 0; i < 40; i++) begin
      drive_sample(127);
      wait_result(32);
      if (i >= 30) begin
        chk("dc_y", longint'(y_out), 125984);
        chk("dc_ys", longint'(y_scaled_out), 123);
        chk("dc_sat", longint'(sat_out), 0);
      end
    end

    // Saturation at both rails.
    set_all_coeffs(511);
    for (int i = 0; i < 31; i++) begin
      drive_sample(127);
      wait_result(32);
    end
    chk("satp_y", longint'(y_out), 2011807);
    chk("satp_ys", longint'(y_scaled_out), 127);
    chk("satp_sat", longint'(sat_out), 1);
    for (int i = 0; i < 31; i++) begin
      drive_sample(-128);
      wait_result(32);
    end
    chk("satn_y", longint'(y_out), -2027648);
    chk("satn_ys", longint'(y_scaled_out), -128);
    chk("satn_sat", longint'(sat_out), 1);

    repeat (3) @(posedge clk_in);
    #1;
    chk("sb_empty", longint'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
